// File: rtl/music_pkg.sv
// Shared types and helpers for the music player datapath: mixer state encoding,
// sample/duration widths and 16-bit saturation.
package music_pkg;

  localparam int SAMPLE_W = 16;
  localparam int DUR_W    = 6;

  typedef enum logic [1:0] {
    MIX_IDLE  = 2'd0,
    MIX_ADDR  = 2'd1,
    MIX_DATA  = 2'd2,
    MIX_SCALE = 2'd3
  } mix_state_t;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] x);
    if (x > 32'sd32767) begin
      return 16'sh7fff;
    end else if (x < -32'sd32768) begin
      return 16'sh8000;
    end else begin
      return x[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/poly_voice_slot.sv
// One voice slot: note step, phase accumulator and beat-driven duration countdown.
// A load always wins over a same-cycle beat decrement or phase advance.
module poly_voice_slot
  import music_pkg::*;
#(
  parameter int STEP_W = 20,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [STEP_W-1:0] step_in,
  input  logic [DUR_W-1:0]  duration_in,
  input  logic              beat_dec,
  input  logic              advance,
  output logic              active,
  output logic              done,
  output logic              step_nz,
  output logic [ADDR_W-1:0] phase_msb
);

  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] phase;
  logic [DUR_W-1:0]  remaining;

  always_ff @(posedge clk) begin
    if (reset) begin
      step      <= '0;
      phase     <= '0;
      remaining <= '0;
      active    <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        step      <= step_in;
        phase     <= '0;
        remaining <= duration_in;
        active    <= (duration_in != '0);
        // A zero-length note is accepted but finishes immediately.
        done      <= (duration_in == '0);
      end else begin
        if (beat_dec && active) begin
          remaining <= remaining - 1'b1;
          if (remaining == DUR_W'(1)) begin
            active <= 1'b0;
            done   <= 1'b1;
          end
        end
        if (advance) begin
          phase <= phase + step;
        end
      end
    end
  end

  assign step_nz   = |step;
  assign phase_msb = phase[STEP_W-1 -: ADDR_W];

endmodule

// File: rtl/poly_note_player.sv
// Polyphonic note player: allocates notes to idle voice slots and, per sample request,
// walks all slots through one shared sine ROM port, then scales and saturates the sum.
module poly_note_player
  import music_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int STEP_W     = 20,
  parameter int ADDR_W     = 10,
  parameter int MIX_SHIFT  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  load_new_note,
  input  logic [STEP_W-1:0]     step_in,
  input  logic [DUR_W-1:0]      duration_in,
  output logic                  load_ready,
  output logic                  note_dropped,
  input  logic                  beat,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [NUM_VOICES-1:0] voice_done,
  input  logic                  generate_next_sample,
  output logic [ADDR_W-1:0]     sine_addr,
  input  logic [SAMPLE_W-1:0]   sine_data,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  new_sample_ready,
  output logic                  sample_overrun,
  output logic [1:0]            mix_state_dbg
);

  localparam int VI_W  = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);

  mix_state_t                state;
  logic [VI_W-1:0]           vidx;
  logic [VI_W-1:0]           next_vidx;
  logic [NUM_VOICES-1:0]     mix_mask;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   data_ext;
  logic signed [31:0]        acc_wide;
  logic signed [31:0]        acc_scaled;

  logic [NUM_VOICES-1:0]     slot_load;
  logic [NUM_VOICES-1:0]     slot_advance;
  logic [NUM_VOICES-1:0]     step_nz;
  logic [ADDR_W-1:0]         phase_msb [NUM_VOICES];

  logic                      alloc_found;
  logic [VI_W-1:0]           alloc_idx;
  logic                      load_accept;
  logic                      beat_dec;

  // Lowest-index idle slot wins; scanning downward leaves the lowest one last.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!voice_active[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = VI_W'(i);
      end
    end
  end

  assign load_ready  = ~(&voice_active);
  assign load_accept = load_new_note && alloc_found;
  assign beat_dec    = beat && play_enable;
  assign next_vidx   = vidx + 1'b1;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    assign slot_load[g]    = load_accept && (alloc_idx == VI_W'(g));
    assign slot_advance[g] = (state == MIX_DATA) && (vidx == VI_W'(g)) &&
                             mix_mask[g] && step_nz[g];

    poly_voice_slot #(
      .STEP_W (STEP_W),
      .ADDR_W (ADDR_W)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .load        (slot_load[g]),
      .step_in     (step_in),
      .duration_in (duration_in),
      .beat_dec    (beat_dec),
      .advance     (slot_advance[g]),
      .active      (voice_active[g]),
      .done        (voice_done[g]),
      .step_nz     (step_nz[g]),
      .phase_msb   (phase_msb[g])
    );
  end

  assign data_ext   = {{(ACC_W-SAMPLE_W){sine_data[SAMPLE_W-1]}}, sine_data};
  assign acc_wide   = {{(32-ACC_W){acc[ACC_W-1]}}, acc};
  assign acc_scaled = acc_wide >>> MIX_SHIFT;
  assign mix_state_dbg = state;

  // sine_addr is loaded on entry to ADDR(v) so the ROM word arrives during DATA(v).
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= MIX_IDLE;
      vidx             <= '0;
      mix_mask         <= '0;
      acc              <= '0;
      sine_addr        <= '0;
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
      sample_overrun   <= 1'b0;
      note_dropped     <= 1'b0;
    end else begin
      new_sample_ready <= 1'b0;
      sample_overrun   <= generate_next_sample && (state != MIX_IDLE);
      note_dropped     <= load_new_note && !load_ready;
      // A slot reloaded mid-mix must keep phase 0 until the next mix.
      mix_mask         <= mix_mask & ~slot_load;
      case (state)
        MIX_IDLE: begin
          if (generate_next_sample && play_enable) begin
            mix_mask  <= voice_active;
            acc       <= '0;
            vidx      <= '0;
            sine_addr <= phase_msb[0];
            state     <= MIX_ADDR;
          end
        end
        MIX_ADDR: begin
          state <= MIX_DATA;
        end
        MIX_DATA: begin
          if (mix_mask[vidx] && step_nz[vidx]) begin
            acc <= acc + data_ext;
          end
          if (vidx == VI_W'(NUM_VOICES - 1)) begin
            state <= MIX_SCALE;
          end else begin
            vidx      <= next_vidx;
            sine_addr <= phase_msb[next_vidx];
            state     <= MIX_ADDR;
          end
        end
        MIX_SCALE: begin
          sample_out       <= sat16(acc_scaled);
          new_sample_ready <= 1'b1;
          state            <= MIX_IDLE;
        end
        default: state <= MIX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_note_player.sv
// Bench for poly_note_player: behavioural sine ROM, a sample scoreboard fed at request
// time and checked on new_sample_ready, plus one task per scenario.
module tb_poly_note_player;

  localparam int NV = 4;
  localparam int SW = 20;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          play_enable = 1'b1;
  logic          load_new_note = 1'b0;
  logic [SW-1:0] step_in = '0;
  logic [5:0]    duration_in = '0;
  logic          load_ready;
  logic          note_dropped;
  logic          beat = 1'b0;
  logic [NV-1:0] voice_active;
  logic [NV-1:0] voice_done;
  logic          generate_next_sample = 1'b0;
  logic [AW-1:0] sine_addr;
  logic [15:0]   sine_data;
  logic [15:0]   sample_out;
  logic          new_sample_ready;
  logic          sample_overrun;
  logic [1:0]    mix_state_dbg;

  int errors = 0;
  int checks = 0;
  int nsr_count = 0;
  logic [15:0] exp_q[$];

  logic        force_en = 1'b0;
  logic [15:0] force_val = '0;

  poly_note_player #(
    .NUM_VOICES (NV),
    .STEP_W     (SW),
    .ADDR_W     (AW),
    .MIX_SHIFT  (0)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .load_new_note        (load_new_note),
    .step_in              (step_in),
    .duration_in          (duration_in),
    .load_ready           (load_ready),
    .note_dropped         (note_dropped),
    .beat                 (beat),
    .voice_active         (voice_active),
    .voice_done           (voice_done),
    .generate_next_sample (generate_next_sample),
    .sine_addr            (sine_addr),
    .sine_data            (sine_data),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready),
    .sample_overrun       (sample_overrun),
    .mix_state_dbg        (mix_state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [15:0] rom_f(input logic [AW-1:0] a);
    return 16'(int'(a) * 30 + 7);
  endfunction

  // Synchronous ROM: data valid one cycle after the address.
  always @(posedge clk) begin
    sine_data <= force_en ? force_val : rom_f(sine_addr);
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && new_sample_ready === 1'b1) begin
      nsr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sample_unexpected: got %0d with no expected sample queued", $signed(sample_out));
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (sample_out !== e) begin
          errors++;
          $display("FAIL sample_value: got %0d expected %0d", $signed(sample_out), $signed(e));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load_new_note = 1'b0;
    beat = 1'b0;
    generate_next_sample = 1'b0;
    play_enable = 1'b1;
    force_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic load_note(input logic [SW-1:0] s, input logic [5:0] d);
    load_new_note = 1'b1;
    step_in = s;
    duration_in = d;
    tick();
    load_new_note = 1'b0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
  endtask

  task automatic mix(input logic [15:0] e, output int lat, output logic [AW-1:0] addr0);
    exp_q.push_back(e);
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    addr0 = sine_addr;
    lat = 1;
    while (new_sample_ready !== 1'b1 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL reset_sample_out: got %0h expected 0", sample_out); end
    checks++; if (sine_addr !== '0) begin errors++; $display("FAIL reset_sine_addr: got %0h expected 0", sine_addr); end
    checks++; if (voice_active !== 4'b0000) begin errors++; $display("FAIL reset_voice_active: got %b expected 0000", voice_active); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready: got %b expected 1", load_ready); end
    checks++; if ({new_sample_ready, sample_overrun, note_dropped, voice_done} !== 7'd0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 0000000", {new_sample_ready, sample_overrun, note_dropped, voice_done});
    end
    checks++; if (mix_state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", mix_state_dbg); end
  endtask

  task automatic test_single_voice();
    int lat;
    logic [AW-1:0] a0;
    do_reset();
    load_note(SW'(1024), 6'd2);
    checks++; if (voice_active !== 4'b0001) begin errors++; $display("FAIL single_active: got %b expected 0001", voice_active); end
    for (int k = 0; k < 10; k++) begin
      mix(rom_f(AW'(k)), lat, a0);
      checks++; if (a0 !== AW'(k)) begin errors++; $display("FAIL single_addr: mix %0d got %0d expected %0d", k, a0, k); end
      checks++; if (lat != 10) begin errors++; $display("FAIL single_latency: mix %0d got %0d expected 10", k, lat); end
    end
    pulse_beat();
    checks++; if (voice_active !== 4'b0001 || voice_done !== 4'b0000) begin
      errors++; $display("FAIL single_beat1: active %b done %b expected 0001/0000", voice_active, voice_done);
    end
    pulse_beat();
    checks++; if (voice_active !== 4'b0000 || voice_done !== 4'b0001) begin
      errors++; $display("FAIL single_expire: active %b done %b expected 0000/0001", voice_active, voice_done);
    end
    tick();
    checks++; if (voice_done !== 4'b0000) begin errors++; $display("FAIL single_done_pulse: got %b expected 0000", voice_done); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_note(SW'(1000), 6'd3);
    load_note(SW'(1000), 6'd3);
    load_note(SW'(1000), 6'd1);
    load_note(SW'(1000), 6'd3);
    checks++; if (voice_active !== 4'b1111 || load_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_full: active %b ready %b expected 1111/0", voice_active, load_ready);
    end
    load_note(SW'(1000), 6'd3);
    checks++; if (note_dropped !== 1'b1 || voice_active !== 4'b1111) begin
      errors++; $display("FAIL b2b_dropped: dropped %b active %b expected 1/1111", note_dropped, voice_active);
    end
    pulse_beat();
    checks++; if (voice_done !== 4'b0100 || voice_active !== 4'b1011 || load_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_expire2: done %b active %b ready %b expected 0100/1011/1", voice_done, voice_active, load_ready);
    end
    load_note(SW'(500), 6'd2);
    checks++; if (voice_active !== 4'b1111 || note_dropped !== 1'b0) begin
      errors++; $display("FAIL b2b_reload: active %b dropped %b expected 1111/0", voice_active, note_dropped);
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [AW-1:0] a0;
    do_reset();
    for (int i = 0; i < 4; i++) load_note(SW'(1000 + i), 6'd5);
    force_en = 1'b1;
    force_val = 16'h7fff;  mix(16'h7fff, lat, a0);
    force_val = 16'h8000;  mix(16'h8000, lat, a0);
    force_val = 16'd1000;  mix(16'd4000, lat, a0);
    force_val = 16'hff9c;  mix(16'hfe70, lat, a0);
    force_en = 1'b0;
  endtask

  task automatic test_beat_and_load();
    do_reset();
    load_note(SW'(1024), 6'd1);
    beat = 1'b1;
    load_note(SW'(2048), 6'd2);
    beat = 1'b0;
    checks++; if (voice_done !== 4'b0001 || voice_active !== 4'b0010) begin
      errors++; $display("FAIL bl_same_edge: done %b active %b expected 0001/0010", voice_done, voice_active);
    end
    pulse_beat();
    checks++; if (voice_active !== 4'b0010 || voice_done !== 4'b0000) begin
      errors++; $display("FAIL bl_full_dur: active %b done %b expected 0010/0000", voice_active, voice_done);
    end
    pulse_beat();
    checks++; if (voice_active !== 4'b0000 || voice_done !== 4'b0010) begin
      errors++; $display("FAIL bl_expire: active %b done %b expected 0000/0010", voice_active, voice_done);
    end
  endtask

  task automatic test_pause();
    int lat;
    int cnt0;
    logic [AW-1:0] a0;
    do_reset();
    load_note(SW'(1024), 6'd3);
    mix(rom_f(AW'(0)), lat, a0);
    tick();
    cnt0 = nsr_count;
    play_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse_beat();
      generate_next_sample = 1'b1;
      tick();
      generate_next_sample = 1'b0;
      repeat (12) tick();
    end
    checks++; if (nsr_count != cnt0) begin errors++; $display("FAIL pause_no_ready: got %0d pulses expected 0", nsr_count - cnt0); end
    checks++; if (sample_out !== rom_f(AW'(0))) begin errors++; $display("FAIL pause_hold: got %0d expected %0d", sample_out, rom_f(AW'(0))); end
    checks++; if (voice_active !== 4'b0001) begin errors++; $display("FAIL pause_active: got %b expected 0001", voice_active); end
    play_enable = 1'b1;
    mix(rom_f(AW'(1)), lat, a0);
    checks++; if (a0 !== AW'(1)) begin errors++; $display("FAIL pause_phase: got %0d expected 1", a0); end
    pulse_beat();
    pulse_beat();
    checks++; if (voice_active !== 4'b0001) begin errors++; $display("FAIL pause_dur_kept: got %b expected 0001", voice_active); end
    pulse_beat();
    checks++; if (voice_done !== 4'b0001 || voice_active !== 4'b0000) begin
      errors++; $display("FAIL pause_expire: done %b active %b expected 0001/0000", voice_done, voice_active);
    end
  endtask

  task automatic test_overrun_and_reset();
    int cnt0;
    do_reset();
    load_note(SW'(1024), 6'd5);
    cnt0 = nsr_count;
    exp_q.push_back(rom_f(AW'(0)));
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    tick();
    tick();
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    checks++; if (sample_overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b expected 1", sample_overrun); end
    tick();
    checks++; if (sample_overrun !== 1'b0) begin errors++; $display("FAIL overrun_width: got %b expected 0", sample_overrun); end
    repeat (15) tick();
    checks++; if (nsr_count - cnt0 != 1) begin errors++; $display("FAIL overrun_one_ready: got %0d expected 1", nsr_count - cnt0); end
    cnt0 = nsr_count;
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (sample_out !== 16'd0) begin errors++; $display("FAIL midreset_sample: got %0h expected 0", sample_out); end
    checks++; if (mix_state_dbg !== 2'd0) begin errors++; $display("FAIL midreset_state: got %0d expected 0", mix_state_dbg); end
    checks++; if (voice_active !== 4'b0000) begin errors++; $display("FAIL midreset_active: got %b expected 0000", voice_active); end
    repeat (12) tick();
    checks++; if (nsr_count != cnt0) begin errors++; $display("FAIL midreset_no_ready: got %0d pulses expected 0", nsr_count - cnt0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_voice();
    test_back_to_back();
    test_saturation();
    test_beat_and_load();
    test_pause();
    test_overrun_and_reset();
    tick();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d samples outstanding expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
